// File: rtl/mips32_pkg.sv
// Shared MIPS32 front-end types and constants.
// Used by the fetch queue and its storage.
package mips32_pkg;

    localparam int WORD_W     = 32;
    localparam int FQ_ENTRY_W = 2 * WORD_W;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t PC_INC = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        word_t pc;
        word_t inst;
    } fq_entry_t;

    function automatic word_t word_align(input word_t a);
        return {a[WORD_W-1:2], 2'b00};
    endfunction

    function automatic word_t pc_next(input word_t pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO holding {pc, inst} entries for the fetch queue.
// Head is read combinationally; flush drops all entries.
module sync_fifo
    import mips32_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = FQ_ENTRY_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  logic [WIDTH-1:0]       i_din,
    output logic [WIDTH-1:0]       o_dout,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // Push and pop together leave the occupancy unchanged.
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch engine: one outstanding memory request feeding a
// small queue of {pc, inst} pairs, with redirect flush and drain.
module ifetch_queue
    import mips32_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e  r_state;
    fetch_state_e  w_state_nxt;
    word_t         r_fetch_pc;
    word_t         w_fetch_pc_nxt;
    word_t         r_req_addr;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_after;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic          w_room_after;
    logic          w_new_req;
    fq_entry_t     w_push_entry;
    fq_entry_t     w_head;

    assign w_pop  = !w_empty && inst_ready && !redirect;
    assign w_push = imem_ack && (r_state == REQ) && !redirect;

    assign w_count_after = w_count + CW'(w_push) - CW'(w_pop);
    assign w_room_after  = (w_count_after < CW'(DEPTH));

    assign w_push_entry.pc   = r_req_addr;
    assign w_push_entry.inst = imem_rdata;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FQ_ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .i_din   (w_push_entry),
        .o_dout  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            if (w_new_req) begin
                r_req_addr <= w_fetch_pc_nxt;
            end
        end
    end

    // In REQ no new issue happens unless the current one is acked, so the
    // space test after an ack already accounts for the in-flight slot.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (!redirect && (w_count < CW'(DEPTH))) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        w_state_nxt = REQ;
                    end else begin
                        w_state_nxt = w_room_after ? REQ : IDLE;
                    end
                end else if (redirect) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    w_state_nxt = REQ;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_fetch_pc_nxt = r_fetch_pc;
        if (redirect) begin
            w_fetch_pc_nxt = word_align(redirect_pc);
        end else if (w_push) begin
            w_fetch_pc_nxt = pc_next(r_fetch_pc);
        end
    end

    // A fresh address is latched only when a new request starts; an open
    // request keeps its address even across redirects.
    assign w_new_req = (w_state_nxt == REQ) &&
                       ((r_state == IDLE) || imem_ack);

    always_comb begin
        imem_req   = (r_state != IDLE);
        imem_addr  = r_req_addr;
        inst_valid = !w_empty;
        inst       = w_head.inst;
        inst_pc    = w_head.pc;
    end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of 2, >=2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port redirect  input  1  taken branch/jump/jr; flushes queue.
REQ-006 SHALL have port redirect_pc  input  32  new fetch address.
REQ-007 SHALL have port imem_req  output  1  instruction-memory request.
REQ-008 SHALL have port imem_addr  output  32  request word address.
REQ-009 SHALL have port imem_ack  input  1  one-cycle response strobe; imem_rdata valid that cycle.
REQ-010 SHALL have port imem_rdata  input  32  fetched instruction.
REQ-011 SHALL have port inst_valid  output  1  queue head valid.
REQ-012 SHALL have port inst_ready  input  1  decode stage consumes head.
REQ-013 SHALL have port inst  output  32  head instruction.
REQ-014 SHALL have port inst_pc  output  32  head instruction address.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, DRAIN.
REQ-016 IDLE->REQ SHALL occur when count + 0 < DEPTH and no redirect this cycle; imem_req=1, imem_addr=fetch_pc registered.
REQ-017 In REQ, imem_req and imem_addr SHALL hold stable until imem_ack; at most one outstanding request.
REQ-018 On imem_ack in REQ without redirect, {fetch_pc, imem_rdata} SHALL be pushed, fetch_pc += 4 (mod 2^32, 0xFFFF_FFFC wraps to 0), next state REQ if space remains after push/pop else IDLE.
REQ-019 Space check SHALL count the in-flight request: issue only if count + outstanding < DEPTH; a push SHALL never overflow.
REQ-020 inst_valid SHALL equal (count != 0); pop on inst_valid & inst_ready; inst/inst_pc SHALL be the head, combinationally from storage.
REQ-021 Simultaneous push and pop SHALL keep count unchanged, including when count == DEPTH.
REQ-022 redirect SHALL clear count to 0 and set fetch_pc = {redirect_pc[31:2], 2'b00} the same edge; a pop in that cycle SHALL be ignored.
REQ-023 redirect while REQ without imem_ack SHALL go to DRAIN; imem_req stays high until ack; acked data SHALL be discarded; DRAIN->REQ on ack.
REQ-024 redirect coincident with imem_ack SHALL discard that data and go to REQ with the new address next cycle.
REQ-025 redirect in DRAIN SHALL update fetch_pc only; latest redirect wins.
REQ-026 Fetch latency: first inst_valid no earlier than 1 cycle after imem_ack; sustained throughput one instruction per ack.
REQ-027 imem_ack outside REQ/DRAIN SHALL be ignored.

Reset
REQ-028 On rst: state IDLE, fetch_pc=RESET_PC, count=0, pointers 0, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0 (storage cleared).
REQ-029 rst mid-request SHALL abandon the request; memory side tolerates a dropped request; late acks ignored in IDLE.
REQ-030 First imem_req SHALL assert on the first clk edge after rst deasserts.

Structure
REQ-031 Word width 32, PC increment 4, FSM state encoding SHALL live in shared package mips32_pkg.
REQ-032 Queue storage SHALL be sub-module sync_fifo (64-bit entries {pc, inst}, DEPTH param, push/pop/flush/count).
REQ-033 Target size 150-300 lines RTL; no latches; no combinational path imem_ack -> imem_req.

Verification
REQ-034 Reset release, memory acks every cycle: imem_addr 0,4,8,...; inst_pc 0,4,8 with matching inst.
REQ-035 inst_ready=0, DEPTH=4: exactly 4 entries queued, imem_req stays low, no overflow; inst_ready=1 resumes fetch at 0x10.
REQ-036 redirect to 0x0000_0103 while request to 0x8 outstanding, ack 3 cycles later: 0x8 data dropped, next imem_addr 0x100, inst_pc 0x100.
REQ-037 redirect coincident with ack and pop: count 0 next cycle, inst_valid=0, next request at redirect address.
REQ-038 redirect_pc 0xFFFF_FFFC: fetched pcs 0xFFFF_FFFC then 0x0000_0000.
REQ-039 rst asserted mid-REQ with 2 queued entries: outputs immediately reset values; fetch restarts at RESET_PC.
